// File: rtl/dcache_sram_arbiter_if.sv
// Bundle of all requester, SRAM-side and response-routing signals of dcache_sram_arbiter.
// The arbiter takes the slave modport; whoever drives the requesters/SRAM takes master.
interface dcache_sram_arbiter_if #(
  parameter int NR_PORTS = 3,
  parameter int WAYS     = 4,
  parameter int INDEX_W  = 12,
  parameter int TAG_W    = 20,
  parameter int LINE_W   = 128,
  parameter int BE_W     = LINE_W / 8,
  parameter int ID_W     = $clog2(NR_PORTS + 1)
) ();

  logic [WAYS-1:0]                  snoop_req_i;
  logic                             snoop_lock_i;
  logic [INDEX_W-1:0]               snoop_addr_i;
  logic [TAG_W-1:0]                 snoop_tag_i;
  logic                             snoop_we_i;
  logic [BE_W-1:0]                  snoop_be_i;
  logic [LINE_W-1:0]                snoop_data_i;
  logic                             snoop_gnt_o;

  logic [NR_PORTS-1:0][WAYS-1:0]    cpu_req_i;
  logic [NR_PORTS-1:0]              cpu_lock_i;
  logic [NR_PORTS-1:0][INDEX_W-1:0] cpu_addr_i;
  logic [NR_PORTS-1:0][TAG_W-1:0]   cpu_tag_i;
  logic [NR_PORTS-1:0]              cpu_we_i;
  logic [NR_PORTS-1:0][BE_W-1:0]    cpu_be_i;
  logic [NR_PORTS-1:0][LINE_W-1:0]  cpu_data_i;
  logic [NR_PORTS-1:0]              cpu_gnt_o;

  logic [WAYS-1:0]                  sram_req_o;
  logic [INDEX_W-1:0]               sram_addr_o;
  logic [TAG_W-1:0]                 sram_tag_o;
  logic                             sram_we_o;
  logic [BE_W-1:0]                  sram_be_o;
  logic [LINE_W-1:0]                sram_data_o;
  logic                             sram_gnt_i;

  logic                             rsp_valid_o;
  logic [ID_W-1:0]                  rsp_id_o;

  modport slave (
    input  snoop_req_i, snoop_lock_i, snoop_addr_i, snoop_tag_i,
    input  snoop_we_i, snoop_be_i, snoop_data_i,
    output snoop_gnt_o,
    input  cpu_req_i, cpu_lock_i, cpu_addr_i, cpu_tag_i,
    input  cpu_we_i, cpu_be_i, cpu_data_i,
    output cpu_gnt_o,
    output sram_req_o, sram_addr_o, sram_tag_o, sram_we_o, sram_be_o, sram_data_o,
    input  sram_gnt_i,
    output rsp_valid_o, rsp_id_o
  );

  modport master (
    output snoop_req_i, snoop_lock_i, snoop_addr_i, snoop_tag_i,
    output snoop_we_i, snoop_be_i, snoop_data_i,
    input  snoop_gnt_o,
    output cpu_req_i, cpu_lock_i, cpu_addr_i, cpu_tag_i,
    output cpu_we_i, cpu_be_i, cpu_data_i,
    input  cpu_gnt_o,
    input  sram_req_o, sram_addr_o, sram_tag_o, sram_we_o, sram_be_o, sram_data_o,
    output sram_gnt_i,
    input  rsp_valid_o, rsp_id_o
  );

endinterface

// File: rtl/dcache_sram_arbiter.sv
// Shares the dcache tag/data SRAM port between the snoop controller (id 0, fixed priority)
// and NR_PORTS round-robin CPU ports; optional snoop starvation guard via DCACHE_SRAM_ARB_STARVE_EN.
module dcache_sram_arbiter #(
  parameter int NR_PORTS     = 3,
  parameter int WAYS         = 4,
  parameter int INDEX_W      = 12,
  parameter int TAG_W        = 20,
  parameter int LINE_W       = 128,
  parameter int BE_W         = LINE_W / 8,
  parameter int STARVE_LIMIT = 8,
  parameter int ID_W         = $clog2(NR_PORTS + 1)
) (
  input logic               clk_i,
  input logic               rst_i,
  dcache_sram_arbiter_if.slave bus
);

  localparam int PTR_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  logic                r_locked;
  logic [ID_W-1:0]     r_owner;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;

  logic                w_locked_d;
  logic [ID_W-1:0]     w_owner_d;
  logic [PTR_W-1:0]    w_rr_ptr_d;

  logic                w_owner_lock;
  logic                w_snoop_elig;
  logic [NR_PORTS-1:0] w_cpu_elig;
  logic                w_cpu_found;
  logic [PTR_W-1:0]    w_cpu_sel;
  logic [PTR_W:0]      w_scan;
  logic                w_override;
  logic                w_any_cpu_req;

  logic                w_win_valid;
  logic                w_win_snoop;
  logic [PTR_W-1:0]    w_win_port;
  logic [ID_W-1:0]     w_win_id;
  logic                w_win_lock;
  logic                w_granted;

  logic [WAYS-1:0]     w_sram_req;
  logic [INDEX_W-1:0]  w_sram_addr;
  logic [TAG_W-1:0]    w_sram_tag;
  logic                w_sram_we;
  logic [BE_W-1:0]     w_sram_be;
  logic [LINE_W-1:0]   w_sram_data;
  logic [NR_PORTS-1:0] w_cpu_gnt;

  assign w_any_cpu_req = |bus.cpu_req_i;

  // Eligibility: while locked, only the owner may compete; also fetch the owner's lock input.
  always_comb begin
    w_owner_lock = 1'b0;
    w_snoop_elig = (|bus.snoop_req_i) && (!r_locked || (r_owner == {ID_W{1'b0}}));
    w_cpu_elig   = {NR_PORTS{1'b0}};
    if (r_owner == {ID_W{1'b0}}) begin
      w_owner_lock = bus.snoop_lock_i;
    end else begin
      w_owner_lock = 1'b0;
    end
    for (int p = 0; p < NR_PORTS; p++) begin
      w_cpu_elig[p] = (|bus.cpu_req_i[p]) && (!r_locked || (r_owner == ID_W'(p + 1)));
      if (r_owner == ID_W'(p + 1)) begin
        w_owner_lock = bus.cpu_lock_i[p];
      end else begin
        w_owner_lock = w_owner_lock;
      end
    end
  end

  // Round-robin scan over CPU ports starting at the pointer, wrapping at NR_PORTS.
  always_comb begin
    w_cpu_found = 1'b0;
    w_cpu_sel   = {PTR_W{1'b0}};
    w_scan      = {(PTR_W+1){1'b0}};
    for (int i = 0; i < NR_PORTS; i++) begin
      w_scan = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
      if (w_scan >= (PTR_W+1)'(NR_PORTS)) begin
        w_scan = w_scan - (PTR_W+1)'(NR_PORTS);
      end else begin
        w_scan = w_scan;
      end
      if (!w_cpu_found && w_cpu_elig[w_scan[PTR_W-1:0]]) begin
        w_cpu_found = 1'b1;
        w_cpu_sel   = w_scan[PTR_W-1:0];
      end else begin
        w_cpu_found = w_cpu_found;
      end
    end
  end

`ifdef DCACHE_SRAM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] r_starve_cnt;

  // A held snoop lock is never broken, so the override only applies outside one.
  assign w_override = (r_starve_cnt == CNT_W'(STARVE_LIMIT)) && w_cpu_found &&
                      !(r_locked && (r_owner == {ID_W{1'b0}}));

  // Counts snoop grants taken while a CPU waits; any CPU grant clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end else if (w_granted && !w_win_snoop) begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end else if (w_granted && w_win_snoop && w_any_cpu_req &&
                 (r_starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end
`else
  assign w_override = 1'b0;
`endif

  // Winner selection and forwarding of the winner's request onto the SRAM port.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_snoop = 1'b0;
    w_win_port  = {PTR_W{1'b0}};
    w_win_id    = {ID_W{1'b0}};
    w_win_lock  = 1'b0;
    w_sram_req  = {WAYS{1'b0}};
    w_sram_addr = {INDEX_W{1'b0}};
    w_sram_tag  = {TAG_W{1'b0}};
    w_sram_we   = 1'b0;
    w_sram_be   = {BE_W{1'b0}};
    w_sram_data = {LINE_W{1'b0}};
    if (w_snoop_elig && !w_override) begin
      w_win_valid = 1'b1;
      w_win_snoop = 1'b1;
      w_win_lock  = bus.snoop_lock_i;
      w_sram_req  = bus.snoop_req_i;
      w_sram_addr = bus.snoop_addr_i;
      w_sram_tag  = bus.snoop_tag_i;
      w_sram_we   = bus.snoop_we_i;
      w_sram_be   = bus.snoop_be_i;
      w_sram_data = bus.snoop_data_i;
    end else if (w_cpu_found) begin
      w_win_valid = 1'b1;
      w_win_port  = w_cpu_sel;
      w_win_id    = ID_W'(w_cpu_sel) + ID_W'(1);
      w_win_lock  = bus.cpu_lock_i[w_cpu_sel];
      w_sram_req  = bus.cpu_req_i[w_cpu_sel];
      w_sram_addr = bus.cpu_addr_i[w_cpu_sel];
      w_sram_tag  = bus.cpu_tag_i[w_cpu_sel];
      w_sram_we   = bus.cpu_we_i[w_cpu_sel];
      w_sram_be   = bus.cpu_be_i[w_cpu_sel];
      w_sram_data = bus.cpu_data_i[w_cpu_sel];
    end else begin
      w_win_valid = 1'b0;
    end
  end

  assign w_granted = w_win_valid && bus.sram_gnt_i;

  // Grant fan-out: only the winner sees sram_gnt_i.
  always_comb begin
    w_cpu_gnt = {NR_PORTS{1'b0}};
    for (int p = 0; p < NR_PORTS; p++) begin
      if (w_granted && !w_win_snoop && (w_win_port == PTR_W'(p))) begin
        w_cpu_gnt[p] = 1'b1;
      end else begin
        w_cpu_gnt[p] = 1'b0;
      end
    end
  end

  // Lock and round-robin next state; release wins over a fresh lock by the same owner.
  always_comb begin
    w_locked_d = r_locked;
    w_owner_d  = r_owner;
    w_rr_ptr_d = r_rr_ptr;
    if (r_locked && !w_owner_lock) begin
      w_locked_d = 1'b0;
    end else if (w_granted && w_win_lock) begin
      w_locked_d = 1'b1;
      w_owner_d  = w_win_id;
    end else begin
      w_locked_d = r_locked;
    end
    if (w_granted && !w_win_snoop) begin
      if (w_win_port == PTR_W'(NR_PORTS - 1)) begin
        w_rr_ptr_d = {PTR_W{1'b0}};
      end else begin
        w_rr_ptr_d = w_win_port + PTR_W'(1);
      end
    end else begin
      w_rr_ptr_d = r_rr_ptr;
    end
  end

  // Arbitration state and the read-response tag that lines up with next-cycle SRAM data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_locked    <= 1'b0;
      r_owner     <= {ID_W{1'b0}};
      r_rr_ptr    <= {PTR_W{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= {ID_W{1'b0}};
    end else begin
      r_locked    <= w_locked_d;
      r_owner     <= w_owner_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_rsp_valid <= w_granted && !w_sram_we;
      if (w_granted && !w_sram_we) begin
        r_rsp_id <= w_win_id;
      end else begin
        r_rsp_id <= r_rsp_id;
      end
    end
  end

  assign bus.snoop_gnt_o = w_granted && w_win_snoop;
  assign bus.cpu_gnt_o   = w_cpu_gnt;
  assign bus.sram_req_o  = w_sram_req;
  assign bus.sram_addr_o = w_sram_addr;
  assign bus.sram_tag_o  = w_sram_tag;
  assign bus.sram_we_o   = w_sram_we;
  assign bus.sram_be_o   = w_sram_be;
  assign bus.sram_data_o = w_sram_data;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_id_o    = r_rsp_id;

endmodule

// File: tb/tb_dcache_sram_arbiter.sv
// Directed bench for dcache_sram_arbiter: vector table plus reset-mid-lock and starvation sequences.
// Starvation expectations follow DCACHE_SRAM_ARB_STARVE_EN.
module tb_dcache_sram_arbiter;

  localparam int NR_PORTS = 3;
  localparam int WAYS     = 4;
  localparam int INDEX_W  = 8;
  localparam int TAG_W    = 8;
  localparam int LINE_W   = 32;
  localparam int BE_W     = 4;
  localparam int ID_W     = 2;
  localparam int NVEC     = 20;

  localparam logic [31:0] SNP_DATA = 32'hDEAD_BEEF;
  localparam logic [31:0] CPU_DATA = 32'hC0DE_0000;

  typedef struct {
    logic       s_req;
    logic       s_lock;
    logic       s_we;
    logic [2:0] c_req;
    logic [2:0] c_lock;
    logic [2:0] c_we;
    logic       gnt;
    logic       e_sgnt;
    logic [2:0] e_cgnt;
    logic [7:0] e_addr;
    logic       e_we;
    logic       e_rv;
    logic [1:0] e_rid;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  vec_t vecs[NVEC];

  dcache_sram_arbiter_if #(
    .NR_PORTS(NR_PORTS), .WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W),
    .LINE_W(LINE_W), .BE_W(BE_W), .ID_W(ID_W)
  ) bus ();

  dcache_sram_arbiter #(
    .NR_PORTS(NR_PORTS), .WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W),
    .LINE_W(LINE_W), .BE_W(BE_W), .STARVE_LIMIT(8), .ID_W(ID_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s_req, input logic s_lock, input logic s_we,
                              input logic [2:0] c_req, input logic [2:0] c_lock,
                              input logic [2:0] c_we, input logic gnt,
                              input logic e_sgnt, input logic [2:0] e_cgnt,
                              input logic [7:0] e_addr, input logic e_we,
                              input logic e_rv, input logic [1:0] e_rid);
    vec_t v;
    v.s_req = s_req;   v.s_lock = s_lock; v.s_we = s_we;
    v.c_req = c_req;   v.c_lock = c_lock; v.c_we = c_we; v.gnt = gnt;
    v.e_sgnt = e_sgnt; v.e_cgnt = e_cgnt; v.e_addr = e_addr;
    v.e_we = e_we;     v.e_rv = e_rv;     v.e_rid = e_rid;
    return v;
  endfunction

  // Forwarded write data / way request are fixed per requester, so they follow from the index.
  function automatic logic [31:0] exp_data(input logic [7:0] a);
    if (a == 8'hA0) return SNP_DATA;
    if (a >= 8'h10 && a <= 8'h12) return CPU_DATA | 32'(a - 8'h10);
    return 32'h0000_0000;
  endfunction

  function automatic logic [3:0] exp_req(input logic [7:0] a);
    if (a == 8'hA0) return 4'b0001;
    if (a >= 8'h10 && a <= 8'h12) return 4'b0010;
    return 4'b0000;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.snoop_req_i  = v.s_req ? 4'b0001 : 4'b0000;
    bus.snoop_lock_i = v.s_lock;
    bus.snoop_we_i   = v.s_we;
    for (int p = 0; p < NR_PORTS; p++) begin
      bus.cpu_req_i[p] = v.c_req[p] ? 4'b0010 : 4'b0000;
    end
    bus.cpu_lock_i = v.c_lock;
    bus.cpu_we_i   = v.c_we;
    bus.sram_gnt_i = v.gnt;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.snoop_addr_i = 8'hA0;
    bus.snoop_tag_i  = 8'h5A;
    bus.snoop_be_i   = 4'hF;
    bus.snoop_data_i = SNP_DATA;
    for (int p = 0; p < NR_PORTS; p++) begin
      bus.cpu_addr_i[p] = 8'h10 + 8'(p);
      bus.cpu_tag_i[p]  = 8'h30 + 8'(p);
      bus.cpu_be_i[p]   = 4'h1 << p;
      bus.cpu_data_i[p] = CPU_DATA | 32'(p);
    end
    drive(mk(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b1,
             1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 2'd0));

    //       s_req  lock  we    c_req   c_lock  c_we    gnt   sgnt  cgnt    addr   we    rv    rid
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 2'd0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 8'hA0, 1'b0, 1'b1, 2'd0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 3'b001, 8'h10, 1'b0, 1'b1, 2'd1);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 3'b010, 8'h11, 1'b0, 1'b1, 2'd2);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 3'b100, 8'h12, 1'b0, 1'b1, 2'd3);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 3'b001, 8'h10, 1'b0, 1'b1, 2'd1);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 8'hA0, 1'b0, 1'b0, 2'd1);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 8'hA0, 1'b0, 1'b0, 2'd1);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 3'b011, 3'b000, 3'b000, 1'b1, 1'b0, 3'b010, 8'h11, 1'b0, 1'b1, 2'd2);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 3'b001, 1'b1, 1'b0, 3'b001, 8'h10, 1'b1, 1'b0, 2'd2);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 8'hA0, 1'b0, 1'b1, 2'd0);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 2'd0);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 2'd0);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 2'd0);
    vecs[14] = mk(1'b1, 1'b0, 1'b1, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 8'hA0, 1'b1, 1'b0, 2'd0);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 1'b0, 3'b001, 8'h10, 1'b0, 1'b1, 2'd1);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 3'b100, 3'b100, 3'b000, 1'b1, 1'b0, 3'b100, 8'h12, 1'b0, 1'b1, 2'd3);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 3'b100, 3'b100, 3'b000, 1'b1, 1'b0, 3'b100, 8'h12, 1'b0, 1'b1, 2'd3);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 2'd3);
    vecs[19] = mk(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 8'hA0, 1'b0, 1'b1, 2'd0);

    // Reset state with no requests present.
    @(negedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 0, 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_rsp_id",    0, 64'(bus.rsp_id_o),    64'd0);
    chk("rst_snoop_gnt", 0, 64'(bus.snoop_gnt_o), 64'd0);
    chk("rst_cpu_gnt",   0, 64'(bus.cpu_gnt_o),   64'd0);
    chk("rst_sram_req",  0, 64'(bus.sram_req_o),  64'd0);
    chk("rst_sram_addr", 0, 64'(bus.sram_addr_o), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      chk("snoop_gnt", i, 64'(bus.snoop_gnt_o), 64'(vecs[i].e_sgnt));
      chk("cpu_gnt",   i, 64'(bus.cpu_gnt_o),   64'(vecs[i].e_cgnt));
      chk("sram_addr", i, 64'(bus.sram_addr_o), 64'(vecs[i].e_addr));
      chk("sram_we",   i, 64'(bus.sram_we_o),   64'(vecs[i].e_we));
      chk("sram_data", i, 64'(bus.sram_data_o), 64'(exp_data(vecs[i].e_addr)));
      chk("sram_req",  i, 64'(bus.sram_req_o),  64'(exp_req(vecs[i].e_addr)));
      @(posedge clk);
      #1;
      chk("rsp_valid", i, 64'(bus.rsp_valid_o), 64'(vecs[i].e_rv));
      chk("rsp_id",    i, 64'(bus.rsp_id_o),    64'(vecs[i].e_rid));
    end

    // CPU1 takes a lock, then reset lands mid-lock without a clock edge.
    @(negedge clk);
    drive(mk(1'b0, 1'b0, 1'b0, 3'b010, 3'b010, 3'b000, 1'b1,
             1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 2'd0));
    #2;
    chk("lk_cpu_gnt", 0, 64'(bus.cpu_gnt_o), 64'b010);
    @(posedge clk);
    #1;
    chk("lk_rsp_id", 0, 64'(bus.rsp_id_o), 64'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_rsp_valid", 0, 64'(bus.rsp_valid_o), 64'd0);
    chk("arst_rsp_id",    0, 64'(bus.rsp_id_o),    64'd0);
    drive(mk(1'b0, 1'b0, 1'b0, 3'b001, 3'b010, 3'b000, 1'b1,
             1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 2'd0));
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("post_rst_cpu_gnt", 0, 64'(bus.cpu_gnt_o), 64'b001);
    @(posedge clk);
    #1;
    chk("post_rst_rsp_id", 0, 64'(bus.rsp_id_o), 64'd1);

    // Snoop and CPU2 requesting back to back.
    for (int i = 0; i < 10; i++) begin
      logic exp_cpu2;
`ifdef DCACHE_SRAM_ARB_STARVE_EN
      exp_cpu2 = (i == 8);
`else
      exp_cpu2 = 1'b0;
`endif
      @(negedge clk);
      drive(mk(1'b1, 1'b0, 1'b0, 3'b100, 3'b000, 3'b000, 1'b1,
               1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 2'd0));
      #2;
      chk("starve_snoop_gnt", i, 64'(bus.snoop_gnt_o), 64'(!exp_cpu2));
      chk("starve_cpu_gnt",   i, 64'(bus.cpu_gnt_o),   64'({exp_cpu2, 2'b00}));
      @(posedge clk);
    end

    @(negedge clk);
    drive(mk(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0,
             1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 2'd0));
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
